// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_pkg
// Purpose  : Shared types and helpers for the multi-channel reset sequencer.
//            - rs_state_t : sequencer state encoding
//            - cnt_width  : width of the shared hold/gap/timeout counter
// Revision : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC        = 3'd0,
        HOLD        = 3'd1,
        RELEASE_ACK = 3'd2,
        GAP         = 3'd3,
        DONE        = 3'd4
    } rs_state_t;

    // One counter serves HOLD, GAP and RELEASE_ACK, so it is sized for the
    // largest of the three terminal counts.
    function automatic int cnt_width(input int hold_cyc,
                                     input int gap_cyc,
                                     input int ack_timeout);
        int m;
        m = hold_cyc;
        if (gap_cyc > m)     m = gap_cyc;
        if (ack_timeout > m) m = ack_timeout;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// Module   : rst_sync
// Purpose  : Asynchronous-assert / synchronous-deassert reset synchroniser,
//            STAGES flops deep.
// Ports    : clk          - system clock
//            arst_n       - raw active-low reset (asynchronous)
//            sync_n       - synchronised reset release (last stage)
//            sync_n_next  - D input of the last stage: high one cycle before
//                           sync_n, i.e. "sync_n rises on this edge"
// Revision : 1.0 - initial release
// ============================================================================
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_n,
    output logic sync_n_next
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_n      = r_chain[STAGES-1];
    assign sync_n_next = r_chain[STAGES-2];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Multi-channel reset release sequencer. Synchronises the board
//            reset, holds every downstream reset for HOLD_CYC cycles, then
//            releases the NUM_CH channel resets one at a time, waiting for
//            each channel's ack (with timeout) and GAP_CYC cycles between
//            releases. A software request restarts the sequence from HOLD.
// Ports    : clk          - system clock
//            irstn        - board reset, asynchronous, active-low
//            sw_rst_req   - synchronous software restart request
//            ch_ack       - per-channel "out of reset" acknowledge
//            orst_n       - per-channel active-low reset outputs
//            all_ready    - every channel released (DONE)
//            timeout_err  - sticky per-channel ack-timeout flags
//            busy         - sequence still in progress
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4,
    parameter int GAP_CYC     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              irstn,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_ack,
    output logic [NUM_CH-1:0] orst_n,
    output logic              all_ready,
    output logic [NUM_CH-1:0] timeout_err,
    output logic              busy
);

    localparam int c_CNT_W = cnt_width(HOLD_CYC, GAP_CYC, ACK_TIMEOUT);
    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Terminal counts are "last value before the exit edge": the counter
    // starts at 0 on entry, so the N-th edge in a state sees N-1.
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST   = c_CH_W'(NUM_CH - 1);
    localparam logic [c_CH_W-1:0]  c_CH_ONE    = c_CH_W'(1);

    rs_state_t           r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CH_W-1:0]   r_ch;
    logic [NUM_CH-1:0]   r_orst_n;
    logic                r_all_ready;
    logic [NUM_CH-1:0]   r_timeout_err;
    logic                r_busy;

    logic                w_sync_n;
    logic                w_sync_n_next;
    logic                w_sync_rel;
    logic                w_ack;
    logic [c_CH_W-1:0]   w_ch_inc;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk         (clk),
        .arst_n      (irstn),
        .sync_n      (w_sync_n),
        .sync_n_next (w_sync_n_next)
    );

    // Leave SYNC on the same edge the synchronised release lands, so HOLD
    // counting starts on the SYNC_STAGES-th edge after irstn rises.
    assign w_sync_rel = w_sync_n_next | w_sync_n;
    assign w_ack      = ch_ack[r_ch];
    assign w_ch_inc   = r_ch + c_CH_ONE;

    always_ff @(posedge clk or negedge irstn) begin
        if (!irstn) begin
            r_state       <= SYNC;
            r_cnt         <= '0;
            r_ch          <= '0;
            r_orst_n      <= '0;
            r_all_ready   <= 1'b0;
            r_timeout_err <= '0;
            r_busy        <= 1'b1;
        end else if (sw_rst_req && (r_state != SYNC)) begin
            // Software restart outranks ack, timeout and gap completion.
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_ch          <= '0;
            r_orst_n      <= '0;
            r_all_ready   <= 1'b0;
            r_timeout_err <= '0;
            r_busy        <= 1'b1;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_sync_rel) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                end

                HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_orst_n[0] <= 1'b1;
                        r_state     <= RELEASE_ACK;
                        r_cnt       <= '0;
                        r_ch        <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                RELEASE_ACK: begin
                    if (w_ack || (r_cnt == c_ACK_LAST)) begin
                        // An ack arriving on the timeout edge still counts.
                        if (!w_ack) begin
                            r_timeout_err[r_ch] <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_ch == c_CH_LAST) begin
                            r_state     <= DONE;
                            r_all_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state <= GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_ch               <= w_ch_inc;
                        r_orst_n[w_ch_inc] <= 1'b1;
                        r_state            <= RELEASE_ACK;
                        r_cnt              <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                DONE: begin
                    // Outputs hold until irstn or a software restart.
                end

                default: begin
                    r_state <= SYNC;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign orst_n      = r_orst_n;
    assign all_ready   = r_all_ready;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. Each sequence is planned
//            from the release rules: start edge S, release R0 = S + HOLD_CYC,
//            channel i exits at R_i + min(d_i, ACK_TIMEOUT) (error when
//            d_i > ACK_TIMEOUT), next release = exit + GAP_CYC. Outputs are
//            compared every cycle against that schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYC    = 4;
    localparam int GAP_CYC     = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int NEVER       = 1000;

    logic              clk = 1'b0;
    logic              irstn;
    logic              sw_rst_req;
    logic [NUM_CH-1:0] ch_ack;
    logic [NUM_CH-1:0] orst_n;
    logic              all_ready;
    logic [NUM_CH-1:0] timeout_err;
    logic              busy;

    reset_sequencer #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYC    (HOLD_CYC),
        .GAP_CYC     (GAP_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .irstn       (irstn),
        .sw_rst_req  (sw_rst_req),
        .ch_ack      (ch_ack),
        .orst_n      (orst_n),
        .all_ready   (all_ready),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference plan for the current sequence.
    int                d   [NUM_CH];
    int                rel [NUM_CH];
    int                ext [NUM_CH];
    logic [NUM_CH-1:0] errf;
    logic [NUM_CH-1:0] tie;
    int                done_cyc;
    logic              in_rst;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic plan(input int s);
        int t;
        int dd;
        t = s + HOLD_CYC;
        for (int i = 0; i < NUM_CH; i++) begin
            dd      = tie[i] ? 1 : d[i];
            rel[i]  = t;
            errf[i] = (dd > ACK_TIMEOUT);
            ext[i]  = t + (errf[i] ? ACK_TIMEOUT : dd);
            t       = ext[i] + GAP_CYC;
        end
        done_cyc = ext[NUM_CH-1];
    endtask

    // Drive acks for the coming edge: channel i acks d_i edges after release.
    task automatic drive_ack();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = !in_rst && (tie[i] || (cyc + 1 >= rel[i] + d[i]));
        end
    endtask

    task automatic check(input string tag);
        logic [NUM_CH-1:0] eo;
        logic [NUM_CH-1:0] ee;
        logic              er;
        logic              eb;
        if (in_rst) begin
            eo = '0; ee = '0; er = 1'b0; eb = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                eo[i] = (cyc >= rel[i]);
                ee[i] = errf[i] && (cyc >= rel[i] + ACK_TIMEOUT);
            end
            er = (cyc >= done_cyc);
            eb = !er;
        end
        n_tests++;
        assert (orst_n === eo) else begin
            n_fail++;
            $error("FAIL %s orst_n cyc=%0d got %b exp %b", tag, cyc, orst_n, eo);
        end
        n_tests++;
        assert (timeout_err === ee) else begin
            n_fail++;
            $error("FAIL %s timeout_err cyc=%0d got %b exp %b", tag, cyc, timeout_err, ee);
        end
        n_tests++;
        assert (all_ready === er) else begin
            n_fail++;
            $error("FAIL %s all_ready cyc=%0d got %b exp %b", tag, cyc, all_ready, er);
        end
        n_tests++;
        assert (busy === eb) else begin
            n_fail++;
            $error("FAIL %s busy cyc=%0d got %b exp %b", tag, cyc, busy, eb);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check(tag);
        drive_ack();
    endtask

    task automatic run_to(input int t, input string tag);
        while (cyc < t) step(tag);
    endtask

    // Software request held for n edges; HOLD restarts on each of them.
    task automatic sw_pulse(input int n, input string tag);
        sw_rst_req = 1'b1;
        repeat (n) begin
            plan(cyc + 1);
            drive_ack();
            step(tag);
        end
        sw_rst_req = 1'b0;
        drive_ack();
    endtask

    // Called just after a negedge: the next posedge is edge 1 after release.
    task automatic power_up();
        irstn  = 1'b1;
        in_rst = 1'b0;
        plan(cyc + SYNC_STAGES);
        drive_ack();
    endtask

    initial begin
        irstn      = 1'b0;
        sw_rst_req = 1'b0;
        ch_ack     = '0;
        in_rst     = 1'b1;
        tie        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d[i] = 1; rel[i] = 0; ext[i] = 0;
        end
        errf     = '0;
        done_cyc = 0;

        repeat (3) step("reset");

        // Power-up, acks tied high.
        tie = '1;
        power_up();
        run_to(done_cyc + 3, "powerup");

        // Software pulse while in DONE.
        sw_pulse(1, "sw_done");
        run_to(done_cyc + 3, "sw_done");

        // Channel 1 never acks; the others are tied high (and ignored early).
        tie  = 4'b1101;
        d[1] = NEVER;
        sw_pulse(1, "ack1_stuck");
        run_to(done_cyc + 3, "ack1_stuck");

        // Channel 2 acks exactly on the timeout edge.
        tie = '0;
        d   = '{1, 3, ACK_TIMEOUT, 2};
        sw_pulse(1, "ack_at_timeout");
        run_to(done_cyc + 3, "ack_at_timeout");

        // Board reset dropped mid-cycle while in GAP with orst_n = 0011.
        tie = '1;
        d   = '{1, 1, 1, 1};
        sw_pulse(2, "pre_drop");
        run_to(rel[1] + 1, "pre_drop");
        #2;
        irstn  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("async_rst");
        drive_ack();
        repeat (2) step("held_rst");

        // Re-release; a software request during SYNC must be ignored.
        power_up();
        sw_rst_req = 1'b1;
        repeat (2) step("sync_sw");
        sw_rst_req = 1'b0;
        run_to(done_cyc + 3, "re_release");

        // Randomised ack latencies, hold lengths and mid-sequence restarts.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d[i]   = int'($urandom_range(1, ACK_TIMEOUT + 3));
                tie[i] = ($urandom_range(0, 5) == 0);
            end
            sw_pulse(int'($urandom_range(1, 3)), "rand_sw");
            if ($urandom_range(0, 2) == 0) begin
                run_to(int'($urandom_range(cyc + 1, done_cyc)), "rand_cut");
            end else begin
                run_to(done_cyc + 3, "rand_full");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
